// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 unit.
//   - CP0 register indices used by the mfc0/mtc0 read/write interface
//   - bit positions of the SR fields (IM, EXL, IE); Cause.IP shares the IM span
//   - hwint_t: one bit per external hardware interrupt line
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  typedef logic [5:0] hwint_t;

endpackage

// File: rtl/cp0_int_sync.sv
// cp0_int_sync: SYNC_STAGES-deep synchronizer for the six asynchronous
// hardware interrupt lines. The last stage is the Cause.IP field.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears every stage
//   hwint_i  raw interrupt lines (asynchronous to clk)
//   ip_o     synchronized interrupt-pending vector
module cp0_int_sync
  import cp0_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  hwint_t hwint_i,
  output hwint_t ip_o
);

  hwint_t stage_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= hwint_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign ip_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the multicycle MIPS core.
// Holds SR (12), Cause (13), EPC (14) and PrID (15), raises Intreq from the
// synchronized hardware interrupt lines, and saves/restores the exception PC.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   PC        resume address, captured into EPC on EXLSet
//   DIn, Wen  mtc0 write data and one-cycle write strobe
//   SEL       CP0 register index for reads and writes
//   EXLSet    interrupt-entry strobe (EXL<=1, EPC<=PC)
//   EXLClr    eret strobe (EXL<=0)
//   HWInt     external level-sensitive interrupt lines
//   Dout      combinational read data selected by SEL
//   Intreq    interrupt request to the controller
//   EPC       exception PC, drives NPC on eret
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID        = 32'h2024_0131,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PC,
  input  logic [31:0] DIn,
  input  logic        Wen,
  input  logic [4:0]  SEL,
  input  logic        EXLSet,
  input  logic        EXLClr,
  input  hwint_t      HWInt,
  output logic [31:0] Dout,
  output logic        Intreq,
  output logic [31:2] EPC
);

  hwint_t      im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [31:2] epc_q, epc_d;
  hwint_t      ip;

  cp0_int_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .hwint_i (HWInt),
    .ip_o    (ip)
  );

  // Later assignments win: EXLSet overrides EXLClr, which overrides an SR
  // write, for EXL; EXLSet overrides an EPC write. IM/IE only come from Wen.
  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    if (Wen && SEL == CP0_SR) begin
      im_d  = DIn[IM_HI:IM_LO];
      ie_d  = DIn[IE_BIT];
      exl_d = DIn[EXL_BIT];
    end
    if (Wen && SEL == CP0_EPC) epc_d = DIn[31:2];
    if (EXLClr) exl_d = 1'b0;
    if (EXLSet) begin
      exl_d = 1'b1;
      epc_d = PC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  assign Intreq = (|(ip & im_q)) & ie_q & ~exl_q;
  assign EPC    = epc_q;

  always_comb begin
    Dout = 32'h0;
    case (SEL)
      CP0_SR:    Dout = {16'h0, im_q, 8'h0, exl_q, ie_q};
      CP0_CAUSE: Dout = {16'h0, ip, 10'h0};
      CP0_EPC:   Dout = {epc_q, 2'b00};
      CP0_PRID:  Dout = PRID;
      default:   Dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:2] PC;
  logic [31:0] DIn;
  logic        Wen;
  logic [4:0]  SEL;
  logic        EXLSet;
  logic        EXLClr;
  hwint_t      HWInt;
  logic [31:0] Dout;
  logic        Intreq;
  logic [31:2] EPC;

  cp0_unit #(
    .PRID        (32'h2024_0131),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PC     (PC),
    .DIn    (DIn),
    .Wen    (Wen),
    .SEL    (SEL),
    .EXLSet (EXLSet),
    .EXLClr (EXLClr),
    .HWInt  (HWInt),
    .Dout   (Dout),
    .Intreq (Intreq),
    .EPC    (EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [31:0] dout;
    logic        intreq;
  } rd_vec_t;

  exp_t    sb[$];
  rd_vec_t vecs[$];
  int      n_checks = 0;
  int      n_pass   = 0;

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] act);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act === e.val) n_pass++;
      else $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
    end
  endtask

  // Read a register via SEL and compare against the expected value.
  task automatic chk_rd(input string name, input logic [4:0] s, input logic [31:0] v);
    SEL = s;
    expect_val(name, v);
    #1;
    check_pop(Dout);
  endtask

  task automatic chk_int(input string name, input logic v);
    expect_val(name, {31'h0, v});
    #1;
    check_pop({31'h0, Intreq});
  endtask

  task automatic chk_epc(input string name, input logic [31:2] v);
    expect_val(name, {2'b00, v});
    #1;
    check_pop({2'b00, EPC});
  endtask

  // Advance one rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    Wen = 1'b1; SEL = s; DIn = d;
    tick();
    clear_strobes();
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      chk_rd({vecs[i].name, "_dout"}, vecs[i].sel, vecs[i].dout);
      chk_int({vecs[i].name, "_intreq"}, vecs[i].intreq);
    end
    vecs.delete();
  endtask

  function automatic rd_vec_t mk(input string n, input logic [4:0] s,
                                 input logic [31:0] d, input logic iq);
    rd_vec_t v;
    v.name = n; v.sel = s; v.dout = d; v.intreq = iq;
    return v;
  endfunction

  initial begin
    rst = 1'b1; PC = '0; DIn = '0; SEL = '0; HWInt = '0;
    clear_strobes();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    vecs.push_back(mk("rst_sr",    CP0_SR,    32'h0, 1'b0));
    vecs.push_back(mk("rst_cause", CP0_CAUSE, 32'h0, 1'b0));
    vecs.push_back(mk("rst_epc",   CP0_EPC,   32'h0, 1'b0));
    vecs.push_back(mk("rst_prid",  CP0_PRID,  32'h2024_0131, 1'b0));
    vecs.push_back(mk("rst_sel7",  5'd7,      32'h0, 1'b0));
    run_vecs();

    // Enable IM[0] and IE, then raise HWInt[0]
    mtc0(CP0_SR, 32'h0000_0401);
    chk_rd("en_sr", CP0_SR, 32'h0000_0401);
    HWInt = 6'b000001;
    tick();
    chk_rd("sync_edge1_cause", CP0_CAUSE, 32'h0);
    chk_int("sync_edge1_intreq", 1'b0);
    tick();
    chk_rd("sync_edge2_cause", CP0_CAUSE, 32'h0000_0400);
    chk_int("sync_edge2_intreq", 1'b1);

    // Interrupt entry
    PC = 30'h0000_0C10; EXLSet = 1'b1;
    tick();
    clear_strobes();
    chk_epc("entry_epc", 30'h0000_0C10);
    vecs.push_back(mk("entry_sr",  CP0_SR,  32'h0000_0403, 1'b0));
    vecs.push_back(mk("entry_epc", CP0_EPC, 32'h0000_3040, 1'b0));
    run_vecs();

    // eret
    EXLClr = 1'b1;
    tick();
    clear_strobes();
    chk_epc("eret_epc", 30'h0000_0C10);
    vecs.push_back(mk("eret_sr", CP0_SR, 32'h0000_0401, 1'b1));
    run_vecs();

    // EXLSet beats an EPC write in the same cycle
    PC = 30'h100; EXLSet = 1'b1; Wen = 1'b1; SEL = CP0_EPC; DIn = 32'hDEAD_BEEC;
    tick();
    clear_strobes();
    chk_epc("prio_epc_exlset", 30'h100);
    chk_rd("prio_sr_exl", CP0_SR, 32'h0000_0403);
    mtc0(CP0_EPC, 32'hDEAD_BEEC);
    chk_rd("wen_epc_dout", CP0_EPC, 32'hDEAD_BEEC);
    chk_epc("wen_epc_port", 30'h37AB_6FBB);

    // EXLClr beats Wen(SR) on EXL, IM/IE still from Wen
    EXLClr = 1'b1; Wen = 1'b1; SEL = CP0_SR; DIn = 32'h0000_0403;
    tick();
    clear_strobes();
    chk_rd("prio_clr_sr", CP0_SR, 32'h0000_0401);

    // EXLSet beats Wen(SR) on EXL, IM/IE from Wen, EPC from PC
    PC = 30'h0000_0ABC; EXLSet = 1'b1; Wen = 1'b1; SEL = CP0_SR; DIn = 32'h0000_0800;
    tick();
    clear_strobes();
    chk_rd("prio_set_sr", CP0_SR, 32'h0000_0802);
    chk_epc("prio_set_epc", 30'h0000_0ABC);

    // Restore SR, check Cause/PrID are not writable
    mtc0(CP0_SR, 32'h0000_0401);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    mtc0(CP0_PRID, 32'h1234_5678);
    mtc0(5'd7, 32'hFFFF_FFFF);
    vecs.push_back(mk("ro_sr",    CP0_SR,    32'h0000_0401, 1'b1));
    vecs.push_back(mk("ro_cause", CP0_CAUSE, 32'h0000_0400, 1'b1));
    vecs.push_back(mk("ro_prid",  CP0_PRID,  32'h2024_0131, 1'b1));
    vecs.push_back(mk("ro_sel7",  5'd7,      32'h0, 1'b1));
    run_vecs();

    // Level-sensitive deassert takes two edges
    HWInt = 6'b000000;
    tick();
    chk_int("deassert_edge1_intreq", 1'b1);
    tick();
    chk_int("deassert_edge2_intreq", 1'b0);
    chk_rd("deassert_cause", CP0_CAUSE, 32'h0);

    // Masked line
    HWInt = 6'b100000;
    tick();
    tick();
    chk_rd("masked_cause", CP0_CAUSE, 32'h0000_8000);
    chk_int("masked_intreq", 1'b0);

    // Async reset between edges
    mtc0(CP0_EPC, 32'h0000_1234);
    HWInt = 6'b000001;
    tick();
    tick();
    chk_int("pre_rst_intreq", 1'b1);
    #2 rst = 1'b1;
    chk_rd("async_rst_sr", CP0_SR, 32'h0);
    chk_rd("async_rst_epc", CP0_EPC, 32'h0);
    chk_rd("async_rst_cause", CP0_CAUSE, 32'h0);
    chk_epc("async_rst_epc_port", 30'h0);
    chk_int("async_rst_intreq", 1'b0);

    // First update after release
    tick();
    rst = 1'b0;
    mtc0(CP0_SR, 32'h0000_0001);
    chk_rd("post_rst_sr", CP0_SR, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
